// File: rtl/tc_pl_cap_data_cap_buff_rd.sv
`default_nettype none
// ============================================================================
// Module   : tc_pl_cap_data_cap_buff_rd
// Brief    : Capture-buffer read-out; splits wide words into OUT_W beats on a
//            valid/ready stream, with credit-throttled reads and a skid FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tc_pl_cap_data_cap_buff_rd #(
    parameter int CAP0_6     = 14,
    parameter int CAP0_15    = 128,
    parameter int OUT_W      = 32,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic [CAP0_6-1:0]  cap_points,
    output logic               buff_dout_req,
    input  logic [CAP0_15-1:0] buff_dout,
    output logic [OUT_W-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic               rd_cmpt
);

    localparam int C_BEATS  = CAP0_15 / OUT_W;
    localparam int C_BEAT_W = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
    localparam int C_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int C_CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(C_BEATS - 1);
    localparam logic [C_CNT_W-1:0]  C_FULL      = C_CNT_W'(FIFO_DEPTH);
    localparam logic [C_CNT_W:0]    C_CREDITS   = (C_CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic [CAP0_6-1:0]     total_q,     total_d;
    logic [CAP0_6-1:0]     issued_q,    issued_d;
    logic [CAP0_6-1:0]     popped_q,    popped_d;
    logic [C_BEAT_W-1:0]   beat_q,      beat_d;
    logic [RD_LAT-1:0]     tag_q,       tag_d;
    logic [C_CNT_W-1:0]    in_flight_q, in_flight_d;
    logic [C_CNT_W-1:0]    count_q,     count_d;
    logic [C_PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [C_PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
    logic                  busy_q,      busy_d;
    logic                  rd_cmpt_q,   rd_cmpt_d;
    logic [CAP0_15-1:0]    mem_q [FIFO_DEPTH];

    logic                  w_push;
    logic                  w_pop;
    logic                  w_fire;
    logic                  w_last_beat;
    logic                  w_last_word;
    logic [C_CNT_W:0]      w_credit_used;
    logic [CAP0_15-1:0]    w_head;

    // Credits cover words still in the read pipe as well as words parked in
    // the FIFO, so every returning word is guaranteed a free slot.
    assign w_credit_used = {1'b0, in_flight_q} + {1'b0, count_q};
    assign buff_dout_req = (state_q == ST_READ) && (issued_q < total_q)
                           && (w_credit_used < C_CREDITS);

    assign w_push      = tag_q[RD_LAT-1];
    assign m_valid     = (count_q != '0);
    assign w_fire      = m_valid && m_ready;
    assign w_last_beat = (beat_q == C_LAST_BEAT);
    assign w_pop       = w_fire && w_last_beat;
    assign w_last_word = (popped_q == (total_q - CAP0_6'(1)));
    assign w_head      = mem_q[rd_ptr_q];

    assign m_data  = m_valid ? w_head[beat_q * OUT_W +: OUT_W] : '0;
    assign m_last  = m_valid && w_last_beat && w_last_word;
    assign busy    = busy_q;
    assign rd_cmpt = rd_cmpt_q;

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        issued_d    = issued_q;
        popped_d    = popped_q;
        beat_d      = beat_q;
        in_flight_d = in_flight_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tag_d       = RD_LAT'({tag_q, buff_dout_req});

        if (buff_dout_req) begin
            issued_d = issued_q + CAP0_6'(1);
        end

        case ({buff_dout_req, w_push})
            2'b10:   in_flight_d = in_flight_q + C_CNT_W'(1);
            2'b01:   in_flight_d = in_flight_q - C_CNT_W'(1);
            default: ;
        endcase

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_W'(1);
            2'b01:   count_d = count_q - C_CNT_W'(1);
            default: ;
        endcase

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
            popped_d = popped_q + CAP0_6'(1);
        end
        if (w_fire) begin
            beat_d = w_last_beat ? '0 : beat_q + C_BEAT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_en) begin
                    total_d  = cap_points;
                    issued_d = '0;
                    popped_d = '0;
                    beat_d   = '0;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                // A zero-length job has nothing to deliver and leaves at once.
                if ((total_q == '0) || (m_last && m_ready)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d    = (state_d != ST_IDLE);
        rd_cmpt_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            total_q     <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            beat_q      <= '0;
            tag_q       <= '0;
            in_flight_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            busy_q      <= 1'b0;
            rd_cmpt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
            beat_q      <= beat_d;
            tag_q       <= tag_d;
            in_flight_q <= in_flight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            busy_q      <= busy_d;
            rd_cmpt_q   <= rd_cmpt_d;
        end
    end

    // Storage needs no reset: the cleared pointers and count hide stale words.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= buff_dout;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (count_q == C_FULL)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_tc_pl_cap_data_cap_buff_rd.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_pl_cap_data_cap_buff_rd
// Brief    : Self-checking bench: cycle tables, a buffer model and a beat-stream
//            reference computed directly from the buffer contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_pl_cap_data_cap_buff_rd;

    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int BEATS      = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_en;
    logic [13:0]  cap_points;
    logic         buff_dout_req;
    logic [127:0] buff_dout;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         busy;
    logic         rd_cmpt;

    int checks = 0;
    int errors = 0;

    logic [127:0] mem [64];
    int           addr;
    logic         hv [0:RD_LAT];
    int           ha [0:RD_LAT];

    always #5 clk = ~clk;

    tc_pl_cap_data_cap_buff_rd dut (
        .clk           (clk),
        .rst           (rst),
        .rd_en         (rd_en),
        .cap_points    (cap_points),
        .buff_dout_req (buff_dout_req),
        .buff_dout     (buff_dout),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .busy          (busy),
        .rd_cmpt       (rd_cmpt)
    );

    typedef struct {
        logic        rd_en;
        logic [13:0] cap;
        logic        ready;
        logic        req;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        cmpt;
        logic        busy;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic [13:0] c, input logic r,
                                input logic q, input logic v, input logic [31:0] d,
                                input logic l, input logic cm, input logic b);
        vec_t t;
        t.rd_en = e; t.cap = c; t.ready = r; t.req = q; t.valid = v;
        t.data = d; t.last = l; t.cmpt = cm; t.busy = b;
        return t;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference beat stream: beat k is slice k%BEATS of word k/BEATS, LSB first.
    function automatic logic [31:0] exp_beat(input int k);
        logic [127:0] w;
        w = mem[(k / BEATS) % 64];
        return w[(k % BEATS) * 32 +: 32];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock, then play the buffer: data for a request seen in
    // cycle c is driven during cycle c+RD_LAT, otherwise noise.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = RD_LAT; i > 0; i--) begin
            hv[i] = hv[i-1];
            ha[i] = ha[i-1];
        end
        hv[0] = buff_dout_req;
        ha[0] = addr;
        if (buff_dout_req) addr++;
        buff_dout = hv[RD_LAT] ? mem[ha[RD_LAT] % 64] : rnd128();
    endtask

    task automatic run_transfer(input int n, input int mode, input int inject, input string nm);
        int  k     = 0;
        int  reqs  = 0;
        int  cmpts = 0;
        bit  done  = 0;
        for (int i = 0; i < n; i++) mem[i] = rnd128();
        addr = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            rd_en      = (cyc == 0) || (cyc == inject);
            cap_points = (cyc == 0) ? 14'(n) : (cyc == inject) ? 14'd5 : 14'($urandom);
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom % 4) != 0;
                2:       m_ready = (cyc > 30);
                default: m_ready = (cyc > 30) && ($urandom % 2 == 1);
            endcase
            if (buff_dout_req) reqs++;
            if (cyc == 1) chk($sformatf("%s_busy", nm), busy, 1);
            if (m_valid) begin
                if (k >= n * BEATS) begin
                    chk($sformatf("%s_extra_beat", nm), k, n * BEATS - 1);
                end else begin
                    chk($sformatf("%s_data%0d", nm, k), m_data, exp_beat(k));
                    chk($sformatf("%s_last%0d", nm, k), m_last, (k == n * BEATS - 1));
                end
                if (m_ready) k++;
            end
            if (cyc == 30 && mode >= 2) begin
                chk($sformatf("%s_hold_reqs", nm), reqs <= FIFO_DEPTH, 1);
                chk($sformatf("%s_hold_valid", nm), m_valid, 1);
                chk($sformatf("%s_hold_nobeat", nm), k, 0);
            end
            if (rd_cmpt) begin
                cmpts++;
                done = 1;
            end
            tick();
        end
        rd_en = 1'b0;
        chk($sformatf("%s_completed", nm), done, 1);
        chk($sformatf("%s_idle_after", nm), {busy, rd_cmpt}, 2'b00);
        chk($sformatf("%s_beats", nm), k, n * BEATS);
        chk($sformatf("%s_reqs", nm), reqs, n);
        chk($sformatf("%s_cmpts", nm), cmpts, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [14];
        logic [127:0] w0;
        int reqs;
        int vcnt;
        int bcnt;

        rst = 1'b1; rd_en = 1'b0; m_ready = 1'b0; cap_points = '0; buff_dout = '0;
        addr = 0;
        for (int i = 0; i <= RD_LAT; i++) begin hv[i] = 1'b0; ha[i] = 0; end
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_outs", {buff_dout_req, m_valid, m_last, busy, rd_cmpt}, 5'b0);
        chk("reset_data", m_data, 0);
        tick();

        // Cycle tables: single word with defaults, then a zero-length job.
        w0 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        vecs[0]  = mk(1, 14'd1, 1, 0, 0, 32'h0,         0, 0, 0);
        vecs[1]  = mk(0, 14'd0, 1, 1, 0, 32'h0,         0, 0, 1);
        vecs[2]  = mk(0, 14'd0, 1, 0, 0, 32'h0,         0, 0, 1);
        vecs[3]  = mk(0, 14'd0, 1, 0, 0, 32'h0,         0, 0, 1);
        vecs[4]  = mk(0, 14'd0, 1, 0, 1, 32'h1111_1111, 0, 0, 1);
        vecs[5]  = mk(0, 14'd0, 1, 0, 1, 32'h2222_2222, 0, 0, 1);
        vecs[6]  = mk(0, 14'd0, 1, 0, 1, 32'h3333_3333, 0, 0, 1);
        vecs[7]  = mk(0, 14'd0, 1, 0, 1, 32'h4444_4444, 1, 0, 1);
        vecs[8]  = mk(0, 14'd0, 1, 0, 0, 32'h0,         0, 1, 1);
        vecs[9]  = mk(0, 14'd0, 1, 0, 0, 32'h0,         0, 0, 0);
        vecs[10] = mk(1, 14'd0, 1, 0, 0, 32'h0,         0, 0, 0);
        vecs[11] = mk(0, 14'd0, 1, 0, 0, 32'h0,         0, 0, 1);
        vecs[12] = mk(0, 14'd0, 1, 0, 0, 32'h0,         0, 1, 1);
        vecs[13] = mk(0, 14'd0, 1, 0, 0, 32'h0,         0, 0, 0);
        mem[0] = w0;
        for (int i = 0; i < 14; i++) begin
            rd_en      = vecs[i].rd_en;
            cap_points = vecs[i].cap;
            m_ready    = vecs[i].ready;
            if (vecs[i].rd_en) addr = 0;
            chk($sformatf("vec%0d_req", i),   buff_dout_req, vecs[i].req);
            chk($sformatf("vec%0d_valid", i), m_valid,       vecs[i].valid);
            chk($sformatf("vec%0d_last", i),  m_last,        vecs[i].last);
            chk($sformatf("vec%0d_cmpt", i),  rd_cmpt,       vecs[i].cmpt);
            chk($sformatf("vec%0d_busy", i),  busy,          vecs[i].busy);
            if (vecs[i].valid) chk($sformatf("vec%0d_data", i), m_data, vecs[i].data);
            tick();
        end
        rd_en = 1'b0;

        run_transfer(3, 0, -1, "w3");
        run_transfer(16, 2, -1, "bp_hold");
        run_transfer(16, 3, -1, "bp_rand");
        run_transfer(2, 0, 3, "ign_start");
        for (int t = 0; t < 6; t++) begin
            run_transfer($urandom_range(1, 12), 1, -1, $sformatf("rnd%0d", t));
        end

        // Reset while two requests are outstanding.
        for (int i = 0; i < 4; i++) mem[i] = rnd128();
        addr = 0; rd_en = 1'b1; cap_points = 14'd4; m_ready = 1'b1;
        tick();
        rd_en = 1'b0;
        reqs = int'(buff_dout_req);
        tick();
        reqs += int'(buff_dout_req);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_inflight", reqs, 2);
        chk("rst_outs", {buff_dout_req, m_valid, m_last, busy, rd_cmpt}, 5'b0);
        chk("rst_data", m_data, 0);
        vcnt = 0; bcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_valid) vcnt++;
            if (busy || rd_cmpt || buff_dout_req) bcnt++;
            tick();
        end
        chk("rst_no_stale_valid", vcnt, 0);
        chk("rst_stays_idle", bcnt, 0);
        run_transfer(1, 0, -1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
